// File: rtl/lpif_rx_strobe_lock.sv
// Receive-side link-lock detector for the x1 LPIF master: watches strobe/marker
// bits on both raw PHY words, runs a HUNT/VERIFY/LOCKED FSM and keeps lock-quality stats.
module lpif_rx_strobe_lock #(
    parameter int unsigned STB_BIT    = 1,
    parameter int unsigned MRK_BIT    = 39,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic        clk_wr,
    input  logic        rst_wr_n,
    input  logic        rx_enable,
    input  logic        clr_counts,
    input  logic [39:0] rx_phy0,
    input  logic [39:0] rx_phy1,
    output logic        rx_online,
    output logic [1:0]  lock_state,
    output logic        lock_loss,
    output logic [15:0] bad_word_count,
    output logic [7:0]  loss_event_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [5:0] STB_IDX  = 6'(STB_BIT);
    localparam logic [5:0] MRK_IDX  = 6'(MRK_BIT);
    localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_COUNT);
    // Marker must be low on PHY 0 and high on PHY 1 (last word of the transfer).
    localparam logic [1:0] MRK_EXP  = 2'b10;

    state_t      state_reg;
    logic [7:0]  good_cnt_reg;
    logic [7:0]  miss_cnt_reg;
    logic        rx_online_reg;
    logic        lock_loss_reg;
    logic [15:0] bad_word_count_reg;
    logic [7:0]  loss_event_count_reg;

    logic [1:0]  stb_bit;
    logic [1:0]  mrk_bit;
    logic [1:0]  lane_ok;
    logic        word_good;
    logic [7:0]  good_inc;
    logic [7:0]  miss_inc;
    logic        bad_in_lock;
    logic        loss_now;
    logic        unused_phy_bits;

    assign stb_bit = {rx_phy1[STB_IDX], rx_phy0[STB_IDX]};
    assign mrk_bit = {rx_phy1[MRK_IDX], rx_phy0[MRK_IDX]};
    assign unused_phy_bits = ^{rx_phy0, rx_phy1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_ok[gi] = stb_bit[gi] & (mrk_bit[gi] == MRK_EXP[gi]);
        end
    endgenerate

    assign word_good   = &lane_ok;
    assign good_inc    = good_cnt_reg + 8'd1;
    assign miss_inc    = miss_cnt_reg + 8'd1;
    assign bad_in_lock = rx_enable && (state_reg == ST_LOCKED) && !word_good;
    assign loss_now    = bad_in_lock && (miss_inc == LOSS_TGT);

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_reg            <= ST_IDLE;
            good_cnt_reg         <= 8'd0;
            miss_cnt_reg         <= 8'd0;
            rx_online_reg        <= 1'b0;
            lock_loss_reg        <= 1'b0;
            bad_word_count_reg   <= 16'd0;
            loss_event_count_reg <= 8'd0;
        end else begin
            lock_loss_reg <= 1'b0;

            // Disable overrides every state and is a silent exit: no loss pulse.
            if (!rx_enable) begin
                state_reg     <= ST_IDLE;
                good_cnt_reg  <= 8'd0;
                miss_cnt_reg  <= 8'd0;
                rx_online_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg    <= ST_HUNT;
                        good_cnt_reg <= 8'd0;
                        miss_cnt_reg <= 8'd0;
                    end
                    ST_HUNT: begin
                        if (word_good) begin
                            if (LOCK_TGT == 8'd1) begin
                                state_reg     <= ST_LOCKED;
                                rx_online_reg <= 1'b1;
                                good_cnt_reg  <= 8'd0;
                            end else begin
                                state_reg    <= ST_VERIFY;
                                good_cnt_reg <= 8'd1;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (!word_good) begin
                            state_reg    <= ST_HUNT;
                            good_cnt_reg <= 8'd0;
                        end else if (good_inc == LOCK_TGT) begin
                            state_reg     <= ST_LOCKED;
                            rx_online_reg <= 1'b1;
                            good_cnt_reg  <= 8'd0;
                        end else begin
                            good_cnt_reg <= good_inc;
                        end
                    end
                    ST_LOCKED: begin
                        if (word_good) begin
                            miss_cnt_reg <= 8'd0;
                        end else if (loss_now) begin
                            state_reg     <= ST_HUNT;
                            miss_cnt_reg  <= 8'd0;
                            good_cnt_reg  <= 8'd0;
                            rx_online_reg <= 1'b0;
                            lock_loss_reg <= 1'b1;
                        end else begin
                            miss_cnt_reg <= miss_inc;
                        end
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        rx_online_reg <= 1'b0;
                    end
                endcase
            end

            // Clear has priority over a same-cycle increment.
            if (clr_counts) begin
                bad_word_count_reg   <= 16'd0;
                loss_event_count_reg <= 8'd0;
            end else begin
                if (bad_in_lock && !(&bad_word_count_reg))
                    bad_word_count_reg <= bad_word_count_reg + 16'd1;
                if (loss_now && !(&loss_event_count_reg))
                    loss_event_count_reg <= loss_event_count_reg + 8'd1;
            end
        end
    end

    assign rx_online        = rx_online_reg;
    assign lock_state       = state_reg;
    assign lock_loss        = lock_loss_reg;
    assign bad_word_count   = bad_word_count_reg;
    assign loss_event_count = loss_event_count_reg;

endmodule

// File: tb/tb_lpif_rx_strobe_lock.sv
// Bench for lpif_rx_strobe_lock: directed vector table, run-length reference model
// under random traffic, saturation/clear on a LOSS_COUNT=255 instance, async reset.
module tb_lpif_rx_strobe_lock;

    localparam int LOCK_N = 8;
    localparam int LOSS_N = 4;
    localparam logic [3:0] GOOD = 4'b1011;  // {p0 stb, p0 mrk, p1 stb, p1 mrk}

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        rx_enable, clr_counts;
    logic [39:0] rx_phy0, rx_phy1;
    logic        rx_online, lock_loss;
    logic [1:0]  lock_state;
    logic [15:0] bad_word_count;
    logic [7:0]  loss_event_count;

    logic        s_enable, s_clr;
    logic [39:0] s_phy0, s_phy1;
    logic        s_online, s_loss;
    logic [1:0]  s_state;
    logic [15:0] s_bad;
    logic [7:0]  s_events;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_rx_strobe_lock dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_enable(rx_enable), .clr_counts(clr_counts),
        .rx_phy0(rx_phy0), .rx_phy1(rx_phy1), .rx_online(rx_online), .lock_state(lock_state),
        .lock_loss(lock_loss), .bad_word_count(bad_word_count), .loss_event_count(loss_event_count)
    );

    lpif_rx_strobe_lock #(.LOCK_COUNT(1), .LOSS_COUNT(255)) dut_sat (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_enable(s_enable), .clr_counts(s_clr),
        .rx_phy0(s_phy0), .rx_phy1(s_phy1), .rx_online(s_online), .lock_state(s_state),
        .lock_loss(s_loss), .bad_word_count(s_bad), .loss_event_count(s_events)
    );

    // Reference model: lock status plus the current good-run and miss-run lengths.
    bit m_idle, m_locked, m_loss;
    int m_run, m_miss, m_bad, m_events;

    function automatic void model_reset();
        m_idle = 1; m_locked = 0; m_loss = 0;
        m_run = 0; m_miss = 0; m_bad = 0; m_events = 0;
    endfunction

    function automatic void model_step(bit en, bit clr, bit good);
        m_loss = 0;
        if (!en) begin
            m_idle = 1; m_locked = 0; m_run = 0; m_miss = 0;
        end else if (m_idle) begin
            m_idle = 0; m_run = 0;
        end else if (!m_locked) begin
            m_run = good ? m_run + 1 : 0;
            if (m_run == LOCK_N) begin
                m_locked = 1; m_run = 0; m_miss = 0;
            end
        end else if (good) begin
            m_miss = 0;
        end else begin
            m_miss++;
            m_bad = (m_bad + 1 > 65535) ? 65535 : m_bad + 1;
            if (m_miss == LOSS_N) begin
                m_locked = 0; m_miss = 0; m_run = 0; m_loss = 1;
                m_events = (m_events + 1 > 255) ? 255 : m_events + 1;
            end
        end
        if (clr) begin
            m_bad = 0; m_events = 0;
        end
    endfunction

    function automatic logic [27:0] model_out();
        logic [1:0] st;
        st = m_idle ? 2'd0 : m_locked ? 2'd3 : (m_run > 0) ? 2'd2 : 2'd1;
        return {st, m_locked && !m_idle, m_loss, 16'(m_bad), 8'(m_events)};
    endfunction

    function automatic logic [27:0] dut_out();
        return {lock_state, rx_online, lock_loss, bad_word_count, loss_event_count};
    endfunction

    function automatic logic [27:0] sat_out();
        return {s_state, s_online, s_loss, s_bad, s_events};
    endfunction

    function automatic logic [39:0] mkword(logic [3:0] w, bit phy);
        logic [63:0] t;
        logic [39:0] r;
        t = {$urandom(), $urandom()};
        r = t[39:0];
        if (!phy) begin r[1] = w[3]; r[39] = w[2]; end
        else      begin r[1] = w[1]; r[39] = w[0]; end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the default instance: drive at negedge, sample 1ns after posedge.
    task automatic cycle(bit en, bit clr, logic [3:0] w, string name);
        rx_enable = en; clr_counts = clr;
        rx_phy0 = mkword(w, 0); rx_phy1 = mkword(w, 1);
        @(posedge clk_wr);
        model_step(en, clr, w == GOOD);
        #1;
        check(name, 32'(dut_out()), 32'(model_out()));
        @(negedge clk_wr);
    endtask

    task automatic sat_cycle(bit clr, bit good);
        s_clr = clr;
        s_phy0 = mkword(good ? GOOD : 4'b1010, 0);
        s_phy1 = mkword(good ? GOOD : 4'b1010, 1);
        @(posedge clk_wr);
        #1;
        @(negedge clk_wr);
    endtask

    typedef struct {
        bit en; bit clr; logic [3:0] w;
        logic [1:0] st; bit onl; bit loss; logic [15:0] bad; logic [7:0] ev;
    } vec_t;
    vec_t vecs[$];

    task automatic add(bit en, bit clr, logic [3:0] w, logic [1:0] st, bit onl, bit loss,
                       logic [15:0] bad, logic [7:0] ev);
        vec_t v;
        v = '{en, clr, w, st, onl, loss, bad, ev};
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        logic [3:0] bad_pat [4];
        int nb, pgood;
        bad_pat[0] = 4'b1010; bad_pat[1] = 4'b0011; bad_pat[2] = 4'b1111; bad_pat[3] = 4'b1001;

        rst_wr_n = 1'b0; rx_enable = 0; clr_counts = 0; rx_phy0 = '0; rx_phy1 = '0;
        s_enable = 0; s_clr = 0; s_phy0 = '0; s_phy1 = '0;
        model_reset();
        repeat (3) @(negedge clk_wr);
        check("reset_values", 32'(dut_out()), 32'd0);
        rst_wr_n = 1'b1;

        for (int i = 0; i < 20; i++) cycle(0, 0, GOOD, "enable_low_idle");

        // Clean lock, loss with an interrupting good word, broken verify, clear, disable.
        add(1, 0, GOOD, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, GOOD, 2, 0, 0, 0, 0);
        add(1, 0, GOOD, 3, 1, 0, 0, 0);
        add(1, 0, GOOD, 3, 1, 0, 0, 0);
        add(1, 0, 4'b1010, 3, 1, 0, 1, 0);
        add(1, 0, 4'b0011, 3, 1, 0, 2, 0);
        add(1, 0, 4'b1111, 3, 1, 0, 3, 0);
        add(1, 0, GOOD,    3, 1, 0, 3, 0);
        add(1, 0, 4'b1001, 3, 1, 0, 4, 0);
        add(1, 0, 4'b1010, 3, 1, 0, 5, 0);
        add(1, 0, 4'b0000, 3, 1, 0, 6, 0);
        add(1, 0, 4'b1010, 1, 0, 1, 7, 1);
        for (int i = 0; i < 5; i++) add(1, 0, GOOD, 2, 0, 0, 7, 1);
        add(1, 0, 4'b1010, 1, 0, 0, 7, 1);
        for (int i = 0; i < 7; i++) add(1, 0, GOOD, 2, 0, 0, 7, 1);
        add(1, 0, GOOD,    3, 1, 0, 7, 1);
        add(1, 1, 4'b1010, 3, 1, 0, 0, 0);
        add(0, 0, GOOD,    0, 0, 0, 0, 0);
        add(0, 0, 4'b1010, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cycle(v.en, v.clr, v.w, "model_vec");
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'({v.st, v.onl, v.loss, v.bad, v.ev}));
        end

        // Random traffic in bursts of varying quality.
        pgood = 90;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) pgood = ($urandom_range(0, 2) == 0) ? 30 : ($urandom_range(0, 1) ? 97 : 75);
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 149) == 0,
                  ($urandom_range(0, 99) < pgood) ? GOOD : bad_pat[$urandom_range(0, 3)],
                  "random_model");
        end

        // Saturation on the LOSS_COUNT=255 instance; default instance parked in IDLE.
        cycle(0, 0, GOOD, "park_idle");
        s_enable = 1'b1;
        sat_cycle(0, 1);
        sat_cycle(0, 1);
        check("sat_locked", 32'(s_state), 32'd3);
        nb = 0;
        for (int i = 0; i < 66000; i++) begin
            if (i % 200 == 199) sat_cycle(0, 1);
            else begin
                sat_cycle(0, 0);
                nb++;
                if (nb == 1000) check("sat_count_1000", 32'(s_bad), 32'd1000);
            end
        end
        check("sat_full", 32'(sat_out()), 32'({2'd3, 1'b1, 1'b0, 16'hFFFF, 8'd0}));
        sat_cycle(1, 0);
        check("sat_clr_wins", 32'(s_bad), 32'd0);
        sat_cycle(0, 0);
        check("sat_after_clr", 32'(s_bad), 32'd1);

        // Lock again, then reset asynchronously between clock edges.
        cycle(1, 0, GOOD, "relock_hunt");
        for (int i = 0; i < LOCK_N; i++) cycle(1, 0, GOOD, "relock");
        cycle(1, 0, 4'b1010, "relock_bad");
        check("pre_reset_locked", 32'(rx_online), 32'd1);
        #2 rst_wr_n = 1'b0;
        #1;
        check("async_reset", 32'(dut_out()), 32'd0);
        check("async_reset_sat", 32'(sat_out()), 32'd0);
        model_reset();
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        s_enable = 1'b0;
        cycle(1, 0, GOOD, "post_reset_hunt");
        cycle(1, 0, GOOD, "post_reset_verify");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
